// File: rtl/sys1_input_pkg.sv
// Shared definitions for the System 1 input controller.
// Joystick and sysmode bit positions, coin stretcher states, sign-extension helper.
// Pure declarations; no logic, no latency.
package sys1_input_pkg;

  // Joystick bit positions (joy1|joy2 combined word)
  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_T1   = 4;
  localparam int JOY_T2   = 5;
  localparam int JOY_T3   = 6;
  localparam int JOY_T4   = 7;
  localparam int JOY_T5   = 8;
  localparam int JOY_ST1  = 9;
  localparam int JOY_ST2  = 10;
  localparam int JOY_COIN = 11;

  // sysmode bit positions
  localparam int SYS_DUAL = 3;
  localparam int SYS_SPIN = 5;

  // Coin stretcher states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_e;

  // Sign-extend an 8-bit delta to the 10-bit accumulation width
  function automatic logic [9:0] sext8(input logic [7:0] v);
    return {{2{v[7]}}, v};
  endfunction

endpackage

// File: rtl/sys1_spin_accum.sv
// Spinner position accumulator: edge detect, mouse/spinner arbitration, delta sum.
// spin_pos updates on the clock edge that samples the event; o_spin_nxt is its combinational next value.
// No backpressure: events arriving while halted are discarded.
module sys1_spin_accum
  import sys1_input_pkg::*;
#(
  parameter int STEP        = 1,
  parameter int FAST_STEP   = 4,
  parameter int MOUSE_SHIFT = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_vs,
  input  logic       i_halt_n,
  input  logic       i_mouse_tog,
  input  logic [8:0] i_mouse_x,
  input  logic       i_spin_tog,
  input  logic [7:0] i_spin_dx,
  input  logic       i_right,
  input  logic       i_left,
  input  logic       i_fast,
  output logic       o_frame_tick,
  output logic [7:0] o_spin_nxt,
  output logic [7:0] o_spin_pos
);

  logic              r_vs_d;
  logic              r_mouse_tog_d;
  logic              r_spin_tog_d;
  logic              r_use_mouse;
  logic [7:0]        r_spin_pos;

  logic              w_mouse_evt;
  logic              w_spin_evt;
  logic              w_use_mouse_nxt;
  logic signed [8:0] w_mouse_x;
  logic signed [8:0] w_mouse_sh;
  logic [9:0]        w_step;
  logic [9:0]        w_sum;
  logic              w_unused_sum_hi;

  assign o_frame_tick = i_vs & ~r_vs_d;
  assign w_mouse_evt  = i_mouse_tog ^ r_mouse_tog_d;
  assign w_spin_evt   = i_spin_tog ^ r_spin_tog_d;

  assign w_mouse_x  = i_mouse_x;
  assign w_mouse_sh = w_mouse_x >>> MOUSE_SHIFT;
  assign w_step     = i_fast ? 10'(FAST_STEP) : 10'(STEP);

  // Source arbitration: a mouse packet claims the position, a spinner sample takes it back and wins ties
  always_comb begin
    w_use_mouse_nxt = r_use_mouse;
    if (w_spin_evt) begin
      w_use_mouse_nxt = 1'b0;
    end else if (w_mouse_evt) begin
      w_use_mouse_nxt = 1'b1;
    end
  end

  // Single-cycle delta sum; the source decision applies to the event that caused it
  always_comb begin
    w_sum = '0;
    if (w_mouse_evt && w_use_mouse_nxt) begin
      w_sum = w_sum + {w_mouse_sh[8], w_mouse_sh};
    end
    // A spinner event always forces the spinner as source, so its term is never masked
    if (w_spin_evt) begin
      w_sum = w_sum + sext8(i_spin_dx);
    end
    if (o_frame_tick) begin
      if (i_right && !i_left) begin
        w_sum = w_sum + w_step;
      end else if (i_left && !i_right) begin
        w_sum = w_sum - w_step;
      end
    end
  end

  // Position wraps modulo 256; the upper sum bits only matter for sign during accumulation
  assign w_unused_sum_hi = ^w_sum[9:8];
  assign o_spin_nxt      = i_halt_n ? (r_spin_pos + w_sum[7:0]) : r_spin_pos;
  assign o_spin_pos      = r_spin_pos;

  // Edge-detect history, source flag and position register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_d        <= 1'b0;
      r_mouse_tog_d <= 1'b0;
      r_spin_tog_d  <= 1'b0;
      r_use_mouse   <= 1'b0;
      r_spin_pos    <= 8'd0;
    end else begin
      r_vs_d        <= i_vs;
      r_mouse_tog_d <= i_mouse_tog;
      r_spin_tog_d  <= i_spin_tog;
      r_use_mouse   <= w_use_mouse_nxt;
      r_spin_pos    <= o_spin_nxt;
    end
  end

endmodule

// File: rtl/sys1_input_ctrl.sv
// Builds the active-low System 1 input bytes from joystick, PS/2 mouse and spinner.
// Outputs registered: 1 clk_sys cycle from any input change.
// No backpressure; coin stretch and spinner position freeze while halt_n is low.
module sys1_input_ctrl
  import sys1_input_pkg::*;
#(
  parameter int STEP        = 1,
  parameter int FAST_STEP   = 4,
  parameter int MOUSE_SHIFT = 1,
  parameter int COIN_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  sysmode,
  input  logic [15:0] joy,
  input  logic [24:0] ps2_mouse,
  input  logic [8:0]  spinner_0,
  input  logic        vs,
  input  logic        halt_n,
  output logic [7:0]  inp0,
  output logic [7:0]  inp1,
  output logic [7:0]  inp2,
  output logic [7:0]  spin_pos
);

  localparam int CNT_W = (COIN_FRAMES < 2) ? 1 : $clog2(COIN_FRAMES + 1);

  coin_state_e      r_state;
  coin_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_coin_d;
  logic [7:0]       r_inp01;
  logic [7:0]       r_inp2;

  logic             w_frame_tick;
  logic [7:0]       w_spin_nxt;
  logic             w_coin;
  logic             w_coin_rise;
  logic             w_coin_act;
  logic             w_trig;
  logic [7:0]       w_inp01;
  logic [7:0]       w_inp2;
  logic             w_unused;

  assign w_unused = ^{sysmode[7:6], sysmode[4], sysmode[2:0],
                      ps2_mouse[23:16], ps2_mouse[7:5], ps2_mouse[3], joy[15:12]};

  sys1_spin_accum #(
    .STEP        (STEP),
    .FAST_STEP   (FAST_STEP),
    .MOUSE_SHIFT (MOUSE_SHIFT)
  ) u_spin_accum (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i_vs         (vs),
    .i_halt_n     (halt_n),
    .i_mouse_tog  (ps2_mouse[24]),
    .i_mouse_x    ({ps2_mouse[4], ps2_mouse[15:8]}),
    .i_spin_tog   (spinner_0[8]),
    .i_spin_dx    (spinner_0[7:0]),
    .i_right      (joy[JOY_R]),
    .i_left       (joy[JOY_L]),
    .i_fast       (joy[JOY_T2]),
    .o_frame_tick (w_frame_tick),
    .o_spin_nxt   (w_spin_nxt),
    .o_spin_pos   (spin_pos)
  );

  assign w_coin      = joy[JOY_COIN];
  assign w_coin_rise = w_coin & ~r_coin_d;

  // Coin stretcher state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_coin_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_coin_d <= w_coin;
    end
  end

  // Coin stretcher next state: hold for COIN_FRAMES unhalted frames, then wait for release
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_coin_rise) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = CNT_W'(COIN_FRAMES);
        end
      end
      HOLD: begin
        if (w_frame_tick && halt_n) begin
          if (r_cnt == '0 || r_cnt == CNT_W'(1)) begin
            w_state_nxt = WAIT_REL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
      end
      WAIT_REL: begin
        if (!w_coin) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Use the next state and next position so every output is one cycle behind its inputs
  assign w_coin_act = (w_state_nxt == HOLD);
  assign w_trig     = joy[JOY_T1] | (|ps2_mouse[2:0]);

  // Output byte selection: spinner mode beats dual-stick beats standard
  always_comb begin
    w_inp01 = 8'hFF;
    w_inp2  = 8'hFF;
    if (sysmode[SYS_SPIN]) begin
      w_inp01 = ~w_spin_nxt;
      w_inp2  = ~{w_trig, w_trig, joy[JOY_ST2], joy[JOY_ST1], 3'b000, w_coin_act};
    end else if (sysmode[SYS_DUAL]) begin
      w_inp01 = ~{joy[JOY_L], joy[JOY_R], joy[JOY_U], joy[JOY_D],
                  joy[JOY_T2], joy[JOY_T1], joy[JOY_T4], joy[JOY_T3]};
      w_inp2  = ~{joy[JOY_T5], joy[JOY_T5], joy[JOY_ST2], joy[JOY_ST1], 3'b000, w_coin_act};
    end else begin
      w_inp01 = ~{joy[JOY_L], joy[JOY_R], joy[JOY_U], joy[JOY_D],
                  1'b0, joy[JOY_T2], joy[JOY_T1], joy[JOY_T3]};
      w_inp2  = ~{2'b00, joy[JOY_ST2], joy[JOY_ST1], 3'b000, w_coin_act};
    end
  end

  // Output registers, idle high (active-low inputs)
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_inp01 <= 8'hFF;
      r_inp2  <= 8'hFF;
    end else begin
      r_inp01 <= w_inp01;
      r_inp2  <= w_inp2;
    end
  end

  assign inp0 = r_inp01;
  assign inp1 = r_inp01;
  assign inp2 = r_inp2;

endmodule
